// File: rtl/cpack_pkg.sv
// Shared types and constants for the C-Pack word encoder.
// Code encodings, code-word lengths and the registered output bundle.
package cpack_pkg;

  localparam int CP_DATA_W = 32;
  localparam int CP_DEPTH  = 16;
  localparam int CP_IDX_W  = $clog2(CP_DEPTH);
  localparam int CP_CNT_W  = $clog2(CP_DEPTH + 1);
  localparam int CP_LEN_W  = 6;
  localparam int CP_LINE_W = 10;

  typedef enum logic [3:0] {
    ZZZZ = 4'b0000,
    XXXX = 4'b0001,
    MMMM = 4'b0010,
    MMXX = 4'b1100,
    ZZZX = 4'b1101,
    MMMX = 4'b1110
  } cpack_code_e;

  // Code-word lengths include the 2- or 4-bit code, the 4-bit index and the payload.
  localparam logic [CP_LEN_W-1:0] LEN_ZZZZ = 6'd2;
  localparam logic [CP_LEN_W-1:0] LEN_MMMM = 6'd6;
  localparam logic [CP_LEN_W-1:0] LEN_ZZZX = 6'd12;
  localparam logic [CP_LEN_W-1:0] LEN_MMMX = 6'd16;
  localparam logic [CP_LEN_W-1:0] LEN_MMXX = 6'd24;
  localparam logic [CP_LEN_W-1:0] LEN_XXXX = 6'd34;

  typedef struct packed {
    cpack_code_e            code;
    logic [CP_IDX_W-1:0]    idx;
    logic [CP_DATA_W-1:0]   payload;
    logic [CP_LEN_W-1:0]    len;
  } cpack_out_t;

endpackage

// File: rtl/cpack_dict_cmp.sv
// Combinational dictionary compare: full / upper-3-byte / upper-2-byte hits.
// Each hit reports the lowest valid entry index; entries at or above cnt_i are ignored.
module cpack_dict_cmp
  import cpack_pkg::*;
(
  input  logic [CP_DATA_W-1:0]          word_i,
  input  logic [CP_DATA_W*CP_DEPTH-1:0] dict_i,
  input  logic [CP_CNT_W-1:0]           cnt_i,
  output logic                          full_hit_o,
  output logic [CP_IDX_W-1:0]           full_idx_o,
  output logic                          b3_hit_o,
  output logic [CP_IDX_W-1:0]           b3_idx_o,
  output logic                          b2_hit_o,
  output logic [CP_IDX_W-1:0]           b2_idx_o
);

  logic [CP_DATA_W-1:0] entry;

  // Scanning downward lets the lowest matching index overwrite any higher one.
  always_comb begin
    full_hit_o = 1'b0;
    full_idx_o = '0;
    b3_hit_o   = 1'b0;
    b3_idx_o   = '0;
    b2_hit_o   = 1'b0;
    b2_idx_o   = '0;
    entry      = '0;
    for (int k = CP_DEPTH - 1; k >= 0; k--) begin
      entry = dict_i[k*CP_DATA_W +: CP_DATA_W];
      if (CP_CNT_W'(k) < cnt_i) begin
        if (entry == word_i) begin
          full_hit_o = 1'b1;
          full_idx_o = CP_IDX_W'(k);
        end
        if (entry[31:8] == word_i[31:8]) begin
          b3_hit_o = 1'b1;
          b3_idx_o = CP_IDX_W'(k);
        end
        if (entry[31:16] == word_i[31:16]) begin
          b2_hit_o = 1'b1;
          b2_idx_o = CP_IDX_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/cpack_word_encoder.sv
// C-Pack pattern-match stage: one word in, one code word out, 1-cycle latency.
// Single output register; accepts whenever it is empty or being drained this cycle.
module cpack_word_encoder
  import cpack_pkg::*;
#(
  parameter int DATA_WIDTH      = CP_DATA_W,
  parameter int WORDS_PER_ENTRY = CP_DEPTH,
  parameter int IDX_W           = $clog2(WORDS_PER_ENTRY)
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset_n,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [DATA_WIDTH-1:0]                 i_word,
  input  logic [DATA_WIDTH*WORDS_PER_ENTRY-1:0] i_dict_data,
  output logic                                  o_dict_wr,
  output logic [DATA_WIDTH-1:0]                 o_dict_wdata,
  output logic                                  o_valid,
  input  logic                                  i_out_ready,
  output logic [3:0]                            o_code,
  output logic [IDX_W-1:0]                      o_idx,
  output logic [DATA_WIDTH-1:0]                 o_payload,
  output logic [CP_LEN_W-1:0]                   o_len,
  output logic                                  o_last,
  output logic [CP_LINE_W-1:0]                  o_line_bits
);

  logic                 full_hit, b3_hit, b2_hit;
  logic [CP_IDX_W-1:0]  full_idx, b3_idx, b2_idx;
  logic                 accept;
  logic [CP_LINE_W-1:0] line_sum;
  cpack_out_t           enc;

  cpack_out_t           out_q, out_d;
  logic                 vld_q, vld_d;
  logic                 last_q, last_d;
  logic [CP_LINE_W-1:0] line_bits_q, line_bits_d;
  logic [CP_LINE_W-1:0] acc_q, acc_d;
  logic [CP_IDX_W-1:0]  wcnt_q, wcnt_d;
  logic [CP_CNT_W-1:0]  dcnt_q, dcnt_d;

  cpack_dict_cmp u_cmp (
    .word_i     (i_word),
    .dict_i     (i_dict_data),
    .cnt_i      (dcnt_q),
    .full_hit_o (full_hit),
    .full_idx_o (full_idx),
    .b3_hit_o   (b3_hit),
    .b3_idx_o   (b3_idx),
    .b2_hit_o   (b2_hit),
    .b2_idx_o   (b2_idx)
  );

  // Priority order matters: zero patterns win over dictionary hits.
  always_comb begin
    enc = '{code: XXXX, idx: '0, payload: i_word, len: LEN_XXXX};
    if (i_word == '0) begin
      enc = '{code: ZZZZ, idx: '0, payload: '0, len: LEN_ZZZZ};
    end else if (full_hit) begin
      enc = '{code: MMMM, idx: full_idx, payload: '0, len: LEN_MMMM};
    end else if (i_word[31:8] == 24'd0) begin
      enc = '{code: ZZZX, idx: '0, payload: {24'd0, i_word[7:0]}, len: LEN_ZZZX};
    end else if (b3_hit) begin
      enc = '{code: MMMX, idx: b3_idx, payload: {24'd0, i_word[7:0]}, len: LEN_MMMX};
    end else if (b2_hit) begin
      enc = '{code: MMXX, idx: b2_idx, payload: {16'd0, i_word[15:0]}, len: LEN_MMXX};
    end
  end

  assign o_ready      = !vld_q || i_out_ready;
  assign accept       = i_valid && o_ready;
  assign o_dict_wr    = accept && (enc.code == XXXX || enc.code == MMXX || enc.code == MMMX);
  assign o_dict_wdata = i_word;
  assign line_sum     = acc_q + CP_LINE_W'(enc.len);

  always_comb begin
    out_d       = out_q;
    vld_d       = vld_q;
    last_d      = last_q;
    line_bits_d = line_bits_q;
    acc_d       = acc_q;
    wcnt_d      = wcnt_q;
    dcnt_d      = dcnt_q;
    if (accept) begin
      out_d  = enc;
      vld_d  = 1'b1;
      last_d = (wcnt_q == CP_IDX_W'(CP_DEPTH - 1));
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == CP_IDX_W'(CP_DEPTH - 1)) begin
        line_bits_d = line_sum;
        acc_d       = '0;
      end else begin
        acc_d = line_sum;
      end
    end else if (i_out_ready) begin
      vld_d = 1'b0;
    end
    // Count tracks the dictionary fill level; once full the FIFO overwrites in place.
    if (o_dict_wr && dcnt_q != CP_CNT_W'(CP_DEPTH)) begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      out_q       <= '{code: ZZZZ, idx: '0, payload: '0, len: '0};
      vld_q       <= 1'b0;
      last_q      <= 1'b0;
      line_bits_q <= '0;
      acc_q       <= '0;
      wcnt_q      <= '0;
      dcnt_q      <= '0;
    end else begin
      out_q       <= out_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
      line_bits_q <= line_bits_d;
      acc_q       <= acc_d;
      wcnt_q      <= wcnt_d;
      dcnt_q      <= dcnt_d;
    end
  end

  assign o_valid     = vld_q;
  assign o_code      = out_q.code;
  assign o_idx       = out_q.idx;
  assign o_payload   = out_q.payload;
  assign o_len       = out_q.len;
  assign o_last      = last_q;
  assign o_line_bits = line_bits_q;

endmodule

// File: tb/tb_cpack_word_encoder.sv
// Scoreboard bench for cpack_word_encoder with a bench-side FIFO dictionary model.
module tb_cpack_word_encoder;

  typedef struct {
    logic [3:0]  code;
    logic [3:0]  idx;
    logic [31:0] payload;
    logic [5:0]  len;
    logic        last;
    logic [9:0]  line;
    logic        push;
  } exp_t;

  logic         i_clk = 1'b0;
  logic         i_reset_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [31:0]  i_word = '0;
  logic [511:0] mdict_bus = '0;
  logic         o_dict_wr;
  logic [31:0]  o_dict_wdata;
  logic         o_valid;
  logic         i_out_ready = 1'b1;
  logic [3:0]   o_code;
  logic [3:0]   o_idx;
  logic [31:0]  o_payload;
  logic [5:0]   o_len;
  logic         o_last;
  logic [9:0]   o_line_bits;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  int   mcnt, mwp, mwcnt, macc, mline;
  logic m_vld;

  cpack_word_encoder dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_word       (i_word),
    .i_dict_data  (mdict_bus),
    .o_dict_wr    (o_dict_wr),
    .o_dict_wdata (o_dict_wdata),
    .o_valid      (o_valid),
    .i_out_ready  (i_out_ready),
    .o_code       (o_code),
    .o_idx        (o_idx),
    .o_payload    (o_payload),
    .o_len        (o_len),
    .o_last       (o_last),
    .o_line_bits  (o_line_bits)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    logic [31:0] ent;
    int f, m3, m2;
    f = -1; m3 = -1; m2 = -1;
    for (int k = 0; k < mcnt; k++) begin
      ent = mdict_bus[k*32 +: 32];
      if (f < 0 && ent == w) f = k;
      if (m3 < 0 && ent[31:8] == w[31:8]) m3 = k;
      if (m2 < 0 && ent[31:16] == w[31:16]) m2 = k;
    end
    e = '{code: 4'b0001, idx: 4'd0, payload: w, len: 6'd34, last: 1'b0, line: 10'd0, push: 1'b1};
    if (w == 0)                 e = '{4'b0000, 4'd0, 32'd0, 6'd2, 1'b0, 10'd0, 1'b0};
    else if (f >= 0)            e = '{4'b0010, 4'(f), 32'd0, 6'd6, 1'b0, 10'd0, 1'b0};
    else if (w[31:8] == 24'd0)  e = '{4'b1101, 4'd0, {24'd0, w[7:0]}, 6'd12, 1'b0, 10'd0, 1'b0};
    else if (m3 >= 0)           e = '{4'b1110, 4'(m3), {24'd0, w[7:0]}, 6'd16, 1'b0, 10'd0, 1'b1};
    else if (m2 >= 0)           e = '{4'b1100, 4'(m2), {16'd0, w[15:0]}, 6'd24, 1'b0, 10'd0, 1'b1};
    return e;
  endfunction

  // One clock cycle, entered and left just after a falling edge.
  task automatic step(input logic vld, input logic [31:0] w, input logic ordy);
    exp_t e;
    logic mready, acc, cons;
    i_valid = vld; i_word = w; i_out_ready = ordy;
    #1;
    mready = !m_vld || ordy;
    chk_eq("o_valid", 32'(o_valid), 32'(m_vld));
    chk_eq("o_ready", 32'(o_ready), 32'(mready));
    if (m_vld) begin
      chk_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb[0];
        chk_eq("o_code", 32'(o_code), 32'(e.code));
        chk_eq("o_idx", 32'(o_idx), 32'(e.idx));
        chk_eq("o_payload", o_payload, e.payload);
        chk_eq("o_len", 32'(o_len), 32'(e.len));
        chk_eq("o_last", 32'(o_last), 32'(e.last));
        chk_eq("o_line_bits", 32'(o_line_bits), 32'(e.line));
      end
    end
    acc  = vld && mready;
    cons = m_vld && ordy;
    if (cons && sb.size() != 0) void'(sb.pop_front());
    e = model(w);
    if (acc) begin
      chk_eq("o_dict_wr", 32'(o_dict_wr), 32'(e.push));
      chk_eq("o_dict_wdata", o_dict_wdata, w);
      e.last = (mwcnt == 15);
      macc   = macc + int'(e.len);
      if (e.last) begin
        mline = macc;
        macc  = 0;
      end
      mwcnt  = (mwcnt + 1) % 16;
      e.line = 10'(mline);
      sb.push_back(e);
    end else begin
      chk_eq("o_dict_wr_idle", 32'(o_dict_wr), 32'd0);
    end
    @(posedge i_clk);
    #1;
    if (acc && e.push) begin
      mdict_bus[mwp*32 +: 32] = w;
      mwp = (mwp + 1) % 16;
      if (mcnt < 16) mcnt++;
    end
    m_vld = acc ? 1'b1 : (cons ? 1'b0 : m_vld);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_reset_n = 1'b0;
    #1;
    chk_eq("rst_o_valid", 32'(o_valid), 32'd0);
    chk_eq("rst_o_code", 32'(o_code), 32'd0);
    chk_eq("rst_o_idx", 32'(o_idx), 32'd0);
    chk_eq("rst_o_payload", o_payload, 32'd0);
    chk_eq("rst_o_len", 32'(o_len), 32'd0);
    chk_eq("rst_o_last", 32'(o_last), 32'd0);
    chk_eq("rst_o_line_bits", 32'(o_line_bits), 32'd0);
    chk_eq("rst_o_ready", 32'(o_ready), 32'd1);
    mdict_bus = '0;
    mcnt = 0; mwp = 0; mwcnt = 0; macc = 0; mline = 0;
    m_vld = 1'b0;
    sb.delete();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
  endtask

  initial begin
    logic [31:0] w;
    logic [15:0] hi_tab [4];
    hi_tab[0] = 16'hDEAD; hi_tab[1] = 16'hBEEF; hi_tab[2] = 16'h0000; hi_tab[3] = 16'h1234;
    @(negedge i_clk);
    do_reset();

    // Zero patterns, then literal / full / partial matches against entry 0.
    step(1, 32'h0000_0000, 1);
    step(1, 32'h0000_0012, 1);
    step(1, 32'hDEAD_BEEF, 1);
    step(1, 32'hDEAD_BEEF, 1);
    step(1, 32'hDEAD_BE01, 1);
    step(1, 32'hDEAD_1234, 1);
    step(0, 32'h0, 1);

    // Two full lines of one repeated word: 124 bits, then 16 x 6 = 96.
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 32'hDEAD_BEEF, 1);
    for (int i = 0; i < 16; i++) step(1, 32'hDEAD_BEEF, 1);
    step(0, 32'h0, 1);
    chk_eq("line2_bits", 32'(mline), 32'd96);

    // Sixteen unrelated literals fill the dictionary; word 17 repeats word 1.
    do_reset();
    for (int i = 0; i < 16; i++) step(1, {8'(i + 1), 8'hA5, 8'(i * 7), 8'h3C}, 1);
    chk_eq("model_cnt_sat", 32'(mcnt), 32'd16);
    step(1, {8'd1, 8'hA5, 8'd0, 8'h3C}, 1);
    step(1, 32'h7777_7777, 1);
    step(1, {8'd1, 8'hA5, 8'd0, 8'h3C}, 1);
    step(1, {8'd2, 8'hA5, 8'd7, 8'h3C}, 1);
    step(0, 32'h0, 1);

    // Backpressure: output held for three cycles while a new word waits.
    step(1, 32'hCAFE_0001, 1);
    for (int i = 0; i < 3; i++) step(1, 32'hCAFE_0002, 0);
    step(1, 32'hCAFE_0002, 1);
    step(0, 32'h0, 1);

    // Randomised traffic with stalls and near-matches.
    for (int i = 0; i < 300; i++) begin
      w = {hi_tab[$urandom_range(0, 3)], 8'($urandom_range(0, 2) * 8'h55), 8'($urandom_range(0, 3))};
      if ($urandom_range(0, 9) == 0) w = 32'd0;
      step(logic'($urandom_range(0, 9) < 8), w, logic'($urandom_range(0, 9) < 7));
    end
    step(0, 32'h0, 1);

    // Reset in the middle of a line with an output pending.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 32'h1111_0000 + 32'(i), 1);
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 32'h2222_0000 + 32'(i % 3), 1);
    step(1, 32'h0, 1);
    step(0, 32'h0, 1);
    step(0, 32'h0, 1);
    chk_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
